instruction_fetch: RTL and testbench

- IF stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID pipeline register.
- Holds the PC and the word-addressed instruction memory.
- Memory is loaded by the debug unit before execution.
- Presents {PC+4, instruction} to IF/ID each cycle; advances under step, stall, branch and jump control; detects HALT.

---
 rtl/instruction_fetch_pkg.sv | 13 +
 rtl/fetch_if.sv | 35 +++
 rtl/instruction_fetch_memory.sv | 23 ++
 rtl/instruction_fetch.sv | 88 ++++++++
 tb/tb_instruction_fetch.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared constants for the MIPS IF stage: FSM encoding, halt encoding, PC stride.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
  localparam int unsigned PC_INC            = 4;

endpackage

// File: rtl/fetch_if.sv
// IF-stage control/data bundle; the fetch unit takes the slave side.
interface fetch_if #(
  parameter int unsigned NBITS     = 32,
  parameter int unsigned MEM_DEPTH = 256
);
  localparam int unsigned CW = $clog2(MEM_DEPTH) + 1;

  logic             i_step;
  logic             i_start;
  logic             i_hazard_detected;
  logic             i_branch_taken;
  logic [NBITS-1:0] i_branch_target;
  logic             i_jump;
  logic [NBITS-1:0] i_jump_target;
  logic             i_load_en;
  logic [NBITS-1:0] i_load_data;
  logic [NBITS-1:0] o_pc;
  logic [NBITS-1:0] o_instruction;
  logic [NBITS-1:0] o_current_pc;
  logic             o_halt;
  logic [CW-1:0]    o_load_count;

  modport master (
    output i_step, i_start, i_hazard_detected, i_branch_taken, i_branch_target,
           i_jump, i_jump_target, i_load_en, i_load_data,
    input  o_pc, o_instruction, o_current_pc, o_halt, o_load_count
  );

  modport slave (
    input  i_step, i_start, i_hazard_detected, i_branch_taken, i_branch_target,
           i_jump, i_jump_target, i_load_en, i_load_data,
    output o_pc, o_instruction, o_current_pc, o_halt, o_load_count
  );

endinterface

// File: rtl/instruction_fetch_memory.sv
// Word-addressed instruction store: synchronous write, asynchronous read, no reset.
module instruction_memory #(
  parameter int unsigned NBITS     = 32,
  parameter int unsigned MEM_DEPTH = 256,
  localparam int unsigned AW       = $clog2(MEM_DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [NBITS-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [NBITS-1:0] rdata
);

  logic [NBITS-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_fetch.sv
// MIPS IF stage: PC register, next-PC selection, LOAD/RUN/HALTED control and load pointer.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned      NBITS     = 32,
  parameter int unsigned      MEM_DEPTH = 256,
  parameter logic [NBITS-1:0] HALT_WORD = NBITS'(HALT_WORD_DEFAULT)
) (
  input logic   i_clk,
  input logic   i_rst,
  fetch_if.slave bus
);

  localparam int unsigned      AW         = $clog2(MEM_DEPTH);
  localparam int unsigned      CW         = AW + 1;
  localparam logic [NBITS-1:0] ALIGN_MASK = ~NBITS'(3);

  fetch_state_t     state, state_next;
  logic [NBITS-1:0] pc, pc_next, pc_plus4, instr;
  logic [CW-1:0]    load_count, load_count_next;
  logic             mem_we;
  logic [AW-1:0]    raddr, waddr;

  // Read index drops the byte offset; upper PC bits wrap modulo MEM_DEPTH.
  assign raddr    = pc[AW+1:2];
  assign waddr    = load_count[AW-1:0];
  assign pc_plus4 = pc + NBITS'(PC_INC);

  instruction_memory #(
    .NBITS     (NBITS),
    .MEM_DEPTH (MEM_DEPTH)
  ) imem (
    .clk   (i_clk),
    .we    (mem_we),
    .waddr (waddr),
    .wdata (bus.i_load_data),
    .raddr (raddr),
    .rdata (instr)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= LOAD;
      pc         <= '0;
      load_count <= '0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      load_count <= load_count_next;
    end
  end

  always_comb begin
    state_next      = state;
    pc_next         = pc;
    load_count_next = load_count;
    mem_we          = 1'b0;
    case (state)
      LOAD: begin
        pc_next = '0;
        // Count doubles as write pointer; saturation at MEM_DEPTH blocks further writes.
        if (bus.i_load_en && (load_count < CW'(MEM_DEPTH))) begin
          mem_we          = 1'b1;
          load_count_next = load_count + CW'(1);
        end
        if (bus.i_start) state_next = RUN;
      end
      RUN: begin
        if (bus.i_step) begin
          if (instr == HALT_WORD)          state_next = HALTED;
          else if (bus.i_hazard_detected)  pc_next    = pc;
          else if (bus.i_jump)             pc_next    = bus.i_jump_target & ALIGN_MASK;
          else if (bus.i_branch_taken)     pc_next    = bus.i_branch_target & ALIGN_MASK;
          else                             pc_next    = pc_plus4;
        end
      end
      HALTED: ;
      default: state_next = LOAD;
    endcase
  end

  assign bus.o_pc          = pc_plus4;
  assign bus.o_instruction = instr;
  assign bus.o_current_pc  = pc;
  assign bus.o_halt        = (state == HALTED);
  assign bus.o_load_count  = load_count;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: expected fetch state queued per driven cycle.
module tb_instruction_fetch;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  typedef struct {
    string       tag;
    logic [31:0] cur;
    logic        halt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_if #(.NBITS(32), .MEM_DEPTH(256)) bus ();

  instruction_fetch #(
    .NBITS     (32),
    .MEM_DEPTH (256),
    .HALT_WORD (HALT)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  exp_t        sb[$];
  logic [31:0] model_mem [256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic compare_head();
    exp_t        e;
    logic [31:0] widx;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      return;
    end
    e    = sb.pop_front();
    widx = {24'd0, e.cur[9:2]};
    check({e.tag, "_cur"},   bus.o_current_pc,        e.cur);
    check({e.tag, "_pc4"},   bus.o_pc,                e.cur + 32'd4);
    check({e.tag, "_instr"}, bus.o_instruction,       model_mem[widx]);
    check({e.tag, "_halt"},  {31'd0, bus.o_halt},     {31'd0, e.halt});
  endtask

  // Queue the expected post-edge state, advance one clock, then score it.
  task automatic cycle(input string tag, input logic [31:0] cur, input logic halt);
    exp_t e;
    e.tag = tag; e.cur = cur; e.halt = halt;
    sb.push_back(e);
    @(posedge clk); #1;
    compare_head();
  endtask

  task automatic load_word(input int unsigned idx, input logic [31:0] data);
    bus.i_load_en   = 1'b1;
    bus.i_load_data = data;
    @(posedge clk); #1;
    bus.i_load_en   = 1'b0;
    if (idx < 256) model_mem[idx] = data;
  endtask

  task automatic clear_ctrl();
    bus.i_step = 0; bus.i_start = 0; bus.i_hazard_detected = 0;
    bus.i_branch_taken = 0; bus.i_branch_target = '0;
    bus.i_jump = 0; bus.i_jump_target = '0;
    bus.i_load_en = 0; bus.i_load_data = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cur"},   bus.o_current_pc,          32'd0);
    check({tag, "_pc4"},   bus.o_pc,                  32'd4);
    check({tag, "_halt"},  {31'd0, bus.o_halt},       32'd0);
    check({tag, "_count"}, {23'd0, bus.o_load_count}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_ctrl();
    #1;
    check_reset_outputs("por");
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Three-word program ending in HALT.
    load_word(0, 32'h2001_0005);
    load_word(1, 32'h2002_0007);
    load_word(2, HALT);
    check("load3_count", {23'd0, bus.o_load_count}, 32'd3);
    bus.i_start = 1; bus.i_step = 1;
    cycle("start", 32'h0, 1'b0);
    bus.i_start = 0;
    cycle("run4", 32'h4, 1'b0);
    cycle("run8", 32'h8, 1'b0);
    cycle("halt", 32'h8, 1'b1);
    bus.i_jump = 1; bus.i_jump_target = 32'h40;
    cycle("halt_hold", 32'h8, 1'b1);
    clear_ctrl();

    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_halted");
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Fill the whole memory, then one extra write that must be dropped.
    for (int unsigned i = 0; i < 256; i++) load_word(i, 32'hA000_0000 + i);
    load_word(256, 32'hDEAD_BEEF);
    check("load_sat", {23'd0, bus.o_load_count}, 32'd256);

    bus.i_start = 1; bus.i_step = 1;
    cycle("start2", 32'h0, 1'b0);
    bus.i_start = 0;

    bus.i_jump = 1; bus.i_jump_target = 32'h10;
    bus.i_branch_taken = 1; bus.i_branch_target = 32'h20;
    cycle("jmp_over_br", 32'h10, 1'b0);
    bus.i_jump = 0; bus.i_branch_target = 32'h23;
    cycle("br_align", 32'h20, 1'b0);
    bus.i_branch_taken = 0; bus.i_jump = 1; bus.i_jump_target = 32'h4;
    cycle("jmp_to_4", 32'h4, 1'b0);
    bus.i_jump = 0;
    bus.i_hazard_detected = 1; bus.i_branch_taken = 1; bus.i_branch_target = 32'h40;
    cycle("stall", 32'h4, 1'b0);
    bus.i_hazard_detected = 0; bus.i_branch_taken = 0;
    cycle("after_stall", 32'h8, 1'b0);

    bus.i_step = 0; bus.i_load_en = 1; bus.i_load_data = 32'h5555_5555;
    for (int unsigned i = 0; i < 5; i++) cycle("step_hold", 32'h8, 1'b0);
    check("run_load_count", {23'd0, bus.o_load_count}, 32'd256);
    bus.i_load_en = 0; bus.i_step = 1;

    bus.i_jump = 1; bus.i_jump_target = 32'h3FC;
    cycle("jmp_top", 32'h3FC, 1'b0);
    bus.i_jump = 0;
    cycle("wrap", 32'h400, 1'b0);
    bus.i_jump = 1; bus.i_jump_target = 32'h14;
    cycle("jmp_14", 32'h14, 1'b0);
    bus.i_jump = 0; bus.i_step = 0;

    // Asynchronous reset asserted between clock edges.
    @(posedge clk); #3;
    rst = 1'b1;
    #1 check_reset_outputs("rst_async");
    bus.i_step = 1;
    cycle("rst_hold_load", 32'h0, 1'b0);
    #1 rst = 1'b0;
    bus.i_start = 1;
    cycle("restart", 32'h0, 1'b0);
    bus.i_start = 0;
    cycle("restart4", 32'h4, 1'b0);
    check("restart_count", {23'd0, bus.o_load_count}, 32'd0);

    check("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
